// File: rtl/ddr2_refresh_sched.sv
// ddr2_refresh_sched: periodic auto-refresh scheduler for the DDR2 controller.
// Raises a refresh demand every TREFI cycles and counts demands that the
// controller has not yet served, up to MAX_POSTPONE. It hands them to the
// controller FSM over a req/ack handshake and holds a tRFC busy window after
// each accepted CMD_REF.
//
// Ports:
//   clk          controller clock
//   rst_n        asynchronous active-low reset
//   init_done    DDR2 init complete; scheduler runs only while high
//   ref_ack      controller issued CMD_REF this cycle
//   ref_req      at least one refresh pending and scheduler ready to hand off
//   ref_urgent   pending_cnt >= URGENT_THRESH
//   ref_busy     tRFC window active, no ACT/REF allowed
//   pending_cnt  outstanding refresh count
//   overflow_err sticky: a tick arrived with pending_cnt == MAX_POSTPONE
module ddr2_refresh_sched #(
    parameter int unsigned TREFI         = 7800,
    parameter int unsigned TRFC          = 26,
    parameter int unsigned MAX_POSTPONE  = 8,
    parameter int unsigned URGENT_THRESH = 6
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              init_done,
    input  logic                              ref_ack,
    output logic                              ref_req,
    output logic                              ref_urgent,
    output logic                              ref_busy,
    output logic [$clog2(MAX_POSTPONE+1)-1:0] pending_cnt,
    output logic                              overflow_err
);

    localparam int unsigned IW = $clog2(TREFI);
    localparam int unsigned RW = $clog2(TRFC + 1);
    localparam int unsigned PW = $clog2(MAX_POSTPONE + 1);

    localparam logic [IW-1:0] IntReload  = IW'(TREFI - 1);
    localparam logic [RW-1:0] RfcReload  = RW'(TRFC - 1);
    localparam logic [PW-1:0] PendMax    = PW'(MAX_POSTPONE);
    localparam logic [PW-1:0] UrgentLvl  = PW'(URGENT_THRESH);

    typedef enum logic [1:0] {StOff, StRun, StRfc} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] int_q, int_d;
    logic [RW-1:0] rfc_q, rfc_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          ovf_q, ovf_d;
    logic          tick;
    logic          accept;

    // Outputs depend on registered state only; ref_ack never reaches them.
    assign ref_req      = (state_q == StRun) && (pend_q != '0);
    assign ref_busy     = (state_q == StRfc);
    assign ref_urgent   = (pend_q >= UrgentLvl);
    assign pending_cnt  = pend_q;
    assign overflow_err = ovf_q;

    assign accept = ref_req && ref_ack;
    assign tick   = (state_q != StOff) && (int_q == '0);

    always_comb begin
        state_d = state_q;
        int_d   = int_q;
        rfc_d   = rfc_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;

        if (!init_done) begin
            // Leaving init wipes the schedule but keeps the sticky error.
            state_d = StOff;
            int_d   = IntReload;
            rfc_d   = '0;
            pend_d  = '0;
        end else begin
            unique case (state_q)
                StOff: state_d = StRun;
                StRun: begin
                    if (accept) begin
                        state_d = StRfc;
                        rfc_d   = RfcReload;
                    end
                end
                StRfc: begin
                    if (rfc_q == '0) begin
                        state_d = StRun;
                    end else begin
                        rfc_d = rfc_q - 1'b1;
                    end
                end
                default: state_d = StOff;
            endcase

            if (state_q != StOff) begin
                int_d = tick ? IntReload : int_q - 1'b1;
            end

            // Tick and accepted ack in the same cycle cancel out.
            if (tick && !accept) begin
                if (pend_q == PendMax) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d = pend_q + 1'b1;
                end
            end else if (accept && !tick) begin
                pend_d = pend_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StOff;
            int_q   <= IntReload;
            rfc_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            rfc_q   <= rfc_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_ddr2_refresh_sched.sv
// tb_ddr2_refresh_sched: directed bench for ddr2_refresh_sched with
// TREFI=100, TRFC=10, MAX_POSTPONE=8, URGENT_THRESH=6. Inputs change and
// outputs are sampled on the falling edge; "after edge N" means the falling
// edge following rising edge N, where edge 0 is the run-entry edge.
module tb_ddr2_refresh_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       init_done;
    logic       ref_ack;
    logic       ref_req;
    logic       ref_urgent;
    logic       ref_busy;
    logic [3:0] pending_cnt;
    logic       overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ddr2_refresh_sched #(
        .TREFI        (100),
        .TRFC         (10),
        .MAX_POSTPONE (8),
        .URGENT_THRESH(6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_done   (init_done),
        .ref_ack     (ref_ack),
        .ref_req     (ref_req),
        .ref_urgent  (ref_urgent),
        .ref_busy    (ref_busy),
        .pending_cnt (pending_cnt),
        .overflow_err(overflow_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_req"}, {31'd0, ref_req}, 0);
        check({tag, "_urg"}, {31'd0, ref_urgent}, 0);
        check({tag, "_busy"}, {31'd0, ref_busy}, 0);
        check({tag, "_pend"}, {28'd0, pending_cnt}, 0);
        check({tag, "_ovf"}, {31'd0, overflow_err}, 0);
    endtask

    // Reset, release, then raise init_done; returns just after edge 0.
    task automatic start_run();
        rst_n     = 1'b0;
        init_done = 1'b0;
        ref_ack   = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        init_done = 1'b1;
        cycles(1);
    endtask

    // One-cycle ack pulse; returns just after the accepting edge.
    task automatic pulse_ack();
        ref_ack = 1'b1;
        cycles(1);
        ref_ack = 1'b0;
    endtask

    // Counts busy cycles over the next n samples, starting with the current one.
    task automatic count_busy(input int n, output int busy_n, output int req_n);
        busy_n = 0;
        req_n  = 0;
        for (int i = 0; i < n; i++) begin
            if (ref_busy) busy_n++;
            if (ref_req) req_n++;
            cycles(1);
        end
    endtask

    int busy_n;
    int req_n;

    initial begin
        rst_n     = 1'b0;
        init_done = 1'b0;
        ref_ack   = 1'b0;
        #2;
        check_idle("rst");

        // Periodic ticks and urgency
        start_run();
        check("t1_req_e0", {31'd0, ref_req}, 0);
        cycles(99);
        check("t1_req_e99", {31'd0, ref_req}, 0);
        cycles(1);
        check("t1_req_e100", {31'd0, ref_req}, 1);
        check("t1_pend_e100", {28'd0, pending_cnt}, 1);
        cycles(100);
        check("t1_pend_e200", {28'd0, pending_cnt}, 2);
        cycles(100);
        check("t1_pend_e300", {28'd0, pending_cnt}, 3);
        cycles(299);
        check("t1_pend_e599", {28'd0, pending_cnt}, 5);
        check("t1_urg_e599", {31'd0, ref_urgent}, 0);
        cycles(1);
        check("t1_pend_e600", {28'd0, pending_cnt}, 6);
        check("t1_urg_e600", {31'd0, ref_urgent}, 1);

        // Single ack and exact tRFC window
        start_run();
        cycles(100);
        check("t2_pend_pre", {28'd0, pending_cnt}, 1);
        pulse_ack();
        check("t2_pend_post", {28'd0, pending_cnt}, 0);
        count_busy(15, busy_n, req_n);
        check("t2_busy_len", busy_n, 10);
        check("t2_req_in_win", req_n, 0);

        // Saturation, overflow, drain; then async reset clears overflow
        start_run();
        cycles(800);
        check("t3_pend_8", {28'd0, pending_cnt}, 8);
        check("t3_ovf_pre", {31'd0, overflow_err}, 0);
        cycles(100);
        check("t3_pend_hold", {28'd0, pending_cnt}, 8);
        check("t3_ovf_set", {31'd0, overflow_err}, 1);
        for (int i = 0; i < 8; i++) begin
            pulse_ack();
            cycles(11);
        end
        check("t3_pend_drain", {28'd0, pending_cnt}, 0);
        check("t3_ovf_sticky", {31'd0, overflow_err}, 1);
        // Now after edge 996; ticks at 1000..1400 bring pending to 5.
        cycles(404);
        check("t6_pend_5", {28'd0, pending_cnt}, 5);
        check("t6_ovf_pre", {31'd0, overflow_err}, 1);
        cycles(50);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("t6_async");
        cycles(1);
        rst_n = 1'b1;

        // Ack coinciding with a tick; ack during busy ignored
        start_run();
        cycles(399);
        check("t4_pend_pre", {28'd0, pending_cnt}, 3);
        pulse_ack();
        check("t4_pend_same", {28'd0, pending_cnt}, 3);
        check("t4_busy", {31'd0, ref_busy}, 1);
        cycles(2);
        pulse_ack();
        check("t4_pend_ign", {28'd0, pending_cnt}, 3);
        check("t4_busy_ign", {31'd0, ref_busy}, 1);
        cycles(1);
        count_busy(10, busy_n, req_n);
        check("t4_busy_rest", busy_n, 6);
        check("t4_req_after", {31'd0, ref_req}, 1);

        // init_done dropped mid-tRFC
        start_run();
        cycles(200);
        check("t5_pend_pre", {28'd0, pending_cnt}, 2);
        pulse_ack();
        cycles(3);
        check("t5_busy_c4", {31'd0, ref_busy}, 1);
        init_done = 1'b0;
        cycles(1);
        check("t5_busy_off", {31'd0, ref_busy}, 0);
        check("t5_pend_off", {28'd0, pending_cnt}, 0);
        check("t5_req_off", {31'd0, ref_req}, 0);
        init_done = 1'b1;
        cycles(1);
        cycles(99);
        check("t5_req_e99", {31'd0, ref_req}, 0);
        cycles(1);
        check("t5_req_e100", {31'd0, ref_req}, 1);
        check("t5_pend_e100", {28'd0, pending_cnt}, 1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
